// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: pipelined IEEE-754-style adder/subtractor with valid/ready flow.
// A pair is captured on acceptance, then S1 unpack/swap/align, S2 add/sub and
// S3 normalise/round/pack feed the output register (3-cycle latency).
// Subnormal inputs and tiny results are flushed to zero; rounding is RNE.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] op_a,
  input  logic [EXP_W+MAN_W:0] op_b,
  input  logic                 op_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [2:0]           flags
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int MW     = MAN_W + 4;        // hidden + fraction + guard/round/sticky
  localparam int SH_MAX = MAN_W + 3;
  localparam int LZ_W   = $clog2(MW);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF} special_t;

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Capture stage
  logic         cap_v, cap_sub;
  logic [W-1:0] cap_a, cap_b;

  // S1 (unpack/swap/align)
  logic             a_sign, b_sign, a_nan, b_nan, a_inf, b_inf, a_big, sticky;
  logic [EXP_W-1:0] a_exp, b_exp, e_big, e_sml, diff, sh;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic [MAN_W:0]   a_m, b_m, m_big, m_sml;
  logic [MW-1:0]    sml_ext, s1_mbig_d, s1_msml_d;
  logic             s1_sign_d;
  special_t         s1_sp_d;

  logic             s1_v, s1_sign, s1_eff_sub;
  special_t         s1_sp;
  logic [EXP_W-1:0] s1_exp;
  logic [MW-1:0]    s1_mbig, s1_msml;

  // S2 (add/sub)
  logic [MW:0]      s2_sum_d;
  logic             s2_sign_d;

  logic             s2_v, s2_sign;
  special_t         s2_sp;
  logic [EXP_W-1:0] s2_exp;
  logic [MW:0]      s2_sum;

  // S3 (normalise/round/pack)
  logic [LZ_W-1:0]  lz;
  logic [MW-1:0]    norm;
  logic [EXP_W+1:0] e_n, e_r;
  logic             round_up;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W-1:0] frac_r;
  logic [W-1:0]     res_d;
  logic [2:0]       flags_d;

  assign a_sign = cap_a[W-1];
  assign b_sign = cap_b[W-1] ^ cap_sub;
  assign a_exp  = cap_a[W-2:MAN_W];
  assign b_exp  = cap_b[W-2:MAN_W];
  assign a_frac = cap_a[MAN_W-1:0];
  assign b_frac = cap_b[MAN_W-1:0];
  assign a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
  assign b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);
  assign a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
  assign b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
  assign a_m    = (a_exp == '0) ? '0 : {1'b1, a_frac};
  assign b_m    = (b_exp == '0) ? '0 : {1'b1, b_frac};

  // Operand capture on handshake; holds when the pipe is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_v   <= 1'b0;
      cap_a   <= '0;
      cap_b   <= '0;
      cap_sub <= 1'b0;
    end else if (advance) begin
      cap_v   <= in_valid;
      cap_a   <= op_a;
      cap_b   <= op_b;
      cap_sub <= op_sub;
    end
  end

  // S1: order by magnitude, align the smaller mantissa, classify specials
  always_comb begin
    a_big     = {a_exp, a_m} >= {b_exp, b_m};
    e_big     = a_big ? a_exp : b_exp;
    e_sml     = a_big ? b_exp : a_exp;
    m_big     = a_big ? a_m : b_m;
    m_sml     = a_big ? b_m : a_m;
    diff      = e_big - e_sml;
    sh        = (diff > EXP_W'(SH_MAX)) ? EXP_W'(SH_MAX) : diff;
    sml_ext   = {m_sml, 3'b000};
    sticky    = |(sml_ext & ~({MW{1'b1}} << sh));
    s1_msml_d = (sml_ext >> sh) | {{(MW-1){1'b0}}, sticky};
    s1_mbig_d = {m_big, 3'b000};
    s1_sign_d = a_big ? a_sign : b_sign;
    s1_sp_d   = SP_NONE;
    if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign))) begin
      s1_sp_d = SP_NAN;
    end else if (a_inf) begin
      s1_sp_d   = SP_INF;
      s1_sign_d = a_sign;
    end else if (b_inf) begin
      s1_sp_d   = SP_INF;
      s1_sign_d = b_sign;
    end
  end

  // S1 pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v       <= 1'b0;
      s1_sign    <= 1'b0;
      s1_eff_sub <= 1'b0;
      s1_sp      <= SP_NONE;
      s1_exp     <= '0;
      s1_mbig    <= '0;
      s1_msml    <= '0;
    end else if (advance) begin
      s1_v       <= cap_v;
      s1_sign    <= s1_sign_d;
      s1_eff_sub <= a_sign ^ b_sign;
      s1_sp      <= s1_sp_d;
      s1_exp     <= e_big;
      s1_mbig    <= s1_mbig_d;
      s1_msml    <= s1_msml_d;
    end
  end

  // S2: magnitude add/sub; exact cancellation yields +0
  always_comb begin
    s2_sum_d  = s1_eff_sub ? ({1'b0, s1_mbig} - {1'b0, s1_msml})
                           : ({1'b0, s1_mbig} + {1'b0, s1_msml});
    s2_sign_d = s1_sign;
    if ((s1_sp == SP_NONE) && s1_eff_sub && (s2_sum_d == '0)) s2_sign_d = 1'b0;
  end

  // S2 pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v    <= 1'b0;
      s2_sign <= 1'b0;
      s2_sp   <= SP_NONE;
      s2_exp  <= '0;
      s2_sum  <= '0;
    end else if (advance) begin
      s2_v    <= s1_v;
      s2_sign <= s2_sign_d;
      s2_sp   <= s1_sp;
      s2_exp  <= s1_exp;
      s2_sum  <= s2_sum_d;
    end
  end

  // S3: normalise, round to nearest-even, detect overflow/underflow, pack
  always_comb begin
    lz = '0;
    for (int unsigned i = 0; i < MW; i++) begin
      if (s2_sum[i]) lz = LZ_W'(MW - 1 - i);
    end
    if (s2_sum[MW]) begin
      // carry out: shift right one, folding the lost bit into sticky
      norm = {s2_sum[MW:2], s2_sum[1] | s2_sum[0]};
      e_n  = {2'b00, s2_exp} + (EXP_W+2)'(1);
    end else begin
      norm = s2_sum[MW-1:0] << lz;
      e_n  = {2'b00, s2_exp} - (EXP_W+2)'(lz);
    end
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r   = {1'b0, norm[MW-1:3]} + (MAN_W+2)'(round_up);
    e_r      = e_n + (EXP_W+2)'(mant_r[MAN_W+1]);
    frac_r   = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];

    res_d   = '0;
    flags_d = '0;
    if (s2_sp == SP_NAN) begin
      res_d   = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
      flags_d = 3'b100;
    end else if (s2_sp == SP_INF) begin
      res_d = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (s2_sum == '0) begin
      res_d   = {s2_sign, {(W-1){1'b0}}};
      flags_d = 3'b001;
    end else if (e_r[EXP_W+1] || (e_r == '0)) begin
      flags_d = 3'b001;
    end else if (e_r >= {2'b00, EXP_ONES}) begin
      res_d   = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
      flags_d = 3'b010;
    end else begin
      res_d = {s2_sign, e_r[EXP_W-1:0], frac_r};
    end
  end

  // Output register; held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (advance) begin
      out_valid <= s2_v;
      result    <= res_d;
      flags     <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Testbench for fp_addsub_pipe: directed corner cases, a stalled stream,
// randomized traffic against an exact-arithmetic reference, and mid-flight reset.
module tb_fp_addsub_pipe;
  logic        clk, rst_n, in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [31:0] op_a, op_b, result;
  logic [2:0]  flags;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [34:0] exp;
  } vec_t;

  vec_t        stim_q[$];
  logic [34:0] exp_q[$];

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Exact reference: operands become integers in units of 2^-149, are summed
  // exactly, then rounded to 24 significant bits (nearest, ties to even).
  function automatic logic [34:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic sub);
    logic         sa, sb, s;
    int           ea, eb, p, sh, be;
    logic [22:0]  fa, fb;
    logic [299:0] va, vb, mag, q, rem, half;
    sa = a[31]; sb = b[31] ^ sub;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = a[22:0]; fb = b[22:0];
    if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0)) return {3'b100, 32'h7FC0_0000};
    if (ea == 255 && eb == 255 && sa != sb) return {3'b100, 32'h7FC0_0000};
    if (ea == 255) return {3'b000, sa, 8'hFF, 23'h0};
    if (eb == 255) return {3'b000, sb, 8'hFF, 23'h0};
    va = (ea == 0) ? 300'(0) : (300'({1'b1, fa}) << (ea - 1));
    vb = (eb == 0) ? 300'(0) : (300'({1'b1, fb}) << (eb - 1));
    if (sa == sb) begin mag = va + vb; s = sa; end
    else if (va >= vb) begin mag = va - vb; s = sa; end
    else begin mag = vb - va; s = sb; end
    if (mag == 0) return {3'b001, (sa == sb) ? sa : 1'b0, 31'h0};
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    if (p < 23) return {3'b001, 32'h0};
    sh  = p - 23;
    q   = mag >> sh;
    rem = mag - (q << sh);
    if (sh > 0) begin
      half = 300'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 300'(1);
    end
    be = p - 22;
    if (q[24]) begin q = q >> 1; be++; end
    if (be <= 0) return {3'b001, 32'h0};
    if (be >= 255) return {3'b010, s, 8'hFF, 23'h0};
    return {3'b000, s, 8'(be), q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op(input logic [31:0] near);
    logic [31:0] r;
    int unsigned k;
    r = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0:       r[30:23] = 8'h00;
      1:       r = {r[31], 8'hFF, 23'h0};
      2:       begin r[30:23] = 8'hFF; r[22] = 1'b1; end
      3, 4, 5: r[30:23] = near[30:23];
      6:       r = near ^ 32'h8000_0000;
      7:       r[30:23] = 8'($urandom_range(240, 254));
      8:       r[30:23] = near[30:23] + 8'd1;
      default: r[30:23] = 8'($urandom_range(1, 254));
    endcase
    return r;
  endfunction

  task automatic push_dir(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [31:0] res, input logic [2:0] fl);
    vec_t v;
    v.a = a; v.b = b; v.sub = sub; v.exp = {fl, res};
    stim_q.push_back(v);
  endtask

  task automatic push_rand(input int n);
    vec_t v;
    logic [31:0] t;
    for (int i = 0; i < n; i++) begin
      v.a = rand_op($urandom);
      v.b = rand_op(v.a);
      if ($urandom_range(0, 1) == 1) begin t = v.a; v.a = v.b; v.b = t; end
      v.sub = 1'($urandom);
      v.exp = ref_model(v.a, v.b, v.sub);
      stim_q.push_back(v);
    end
  endtask

  // One clock cycle: drive at edge+1, sample at edge+7, advance to next edge+1.
  task automatic step(input logic ordy);
    vec_t v;
    v = '0;
    out_ready = ordy;
    if (stim_q.size() != 0) begin
      v = stim_q[0];
      in_valid = 1'b1; op_a = v.a; op_b = v.b; op_sub = v.sub;
    end else begin
      in_valid = 1'b0; op_a = $urandom; op_b = $urandom; op_sub = 1'($urandom);
    end
    #6;
    if (ordy) check("in_ready_free", 64'(in_ready), 64'd1);
    if (out_valid && !ordy) begin
      check("in_ready_stall", 64'(in_ready), 64'd0);
      if (exp_q.size() != 0) check("stall_hold", 64'({flags, result}), 64'(exp_q[0]));
    end
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) check("unexpected_out", 64'(out_valid), 64'd0);
      else check("result", 64'({flags, result}), 64'(exp_q.pop_front()));
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(v.exp);
      void'(stim_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((stim_q.size() != 0 || exp_q.size() != 0) && n < max_cycles) begin
      step(1'b1);
      n++;
    end
    check("drain_timeout", 64'(stim_q.size() + exp_q.size()), 64'd0);
    stim_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check("rst_hold_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;

    // Latency: accept on first edge after release, result after exactly 3 edges
    in_valid = 1'b1; op_a = 32'h3F80_0000; op_b = 32'h3F80_0000; op_sub = 1'b0;
    #6 check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_k0", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_k1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_k2", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_k3", 64'(out_valid), 64'd1);
    check("one_plus_one", 64'({flags, result}), 64'({3'b000, 32'h4000_0000}));
    @(posedge clk); #1;
    check("lat_consumed", 64'(out_valid), 64'd0);

    // Directed corner cases
    push_dir(32'h3FC0_0000, 32'hC020_0000, 1'b1, 32'h4080_0000, 3'b000);
    push_dir(32'h4040_0000, 32'h4040_0000, 1'b1, 32'h0000_0000, 3'b001);
    push_dir(32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 3'b100);
    push_dir(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 3'b010);
    push_dir(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 3'b000);
    push_dir(32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002, 3'b000);
    push_dir(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 3'b001);
    push_dir(32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 3'b100);
    push_dir(32'hFF80_0000, 32'h3F80_0000, 1'b0, 32'hFF80_0000, 3'b000);
    push_dir(32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, 3'b000);
    push_dir(32'h0040_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 3'b001);
    push_dir(32'h0080_0000, 32'h00C0_0000, 1'b1, 32'h0000_0000, 3'b001);
    push_dir(32'h3F80_0000, 32'h0040_0000, 1'b0, 32'h3F80_0000, 3'b000);
    drain(100);

    // Back-to-back stream of 8 with a 4-cycle consumer stall mid-stream
    push_rand(8);
    for (int c = 0; c < 20; c++) begin
      if (c >= 4 && c < 8) check("stall_out_valid", 64'(out_valid), 64'd1);
      step(!(c >= 4 && c < 8));
    end
    drain(50);

    // Randomized traffic with random back-pressure
    push_rand(300);
    for (int c = 0; c < 2000 && (stim_q.size() != 0 || exp_q.size() != 0); c++) begin
      step($urandom_range(0, 3) != 0);
    end
    drain(100);

    // Reset with operations in flight
    push_rand(3);
    for (int c = 0; c < 3; c++) step(1'b1);
    step(1'b0);
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_flags", 64'(flags), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    stim_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      check("post_reset_quiet", 64'(out_valid), 64'd0);
      step(1'b1);
    end
    push_dir(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 3'b000);
    drain(20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
